// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter fetch controller with free-run, count-limited and single-step modes,
// branch redirect, stall/backpressure, halt, saturating issue counter and a one-cycle done pulse.
module pc_sequencer #(
  parameter int PC_WIDTH = 32,
  parameter int PC_STEP = 1,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [CNT_WIDTH-1:0] i_run_count,
  input  logic [PC_WIDTH-1:0]  i_start_pc,
  input  logic                 i_step,
  input  logic                 i_halt,
  input  logic                 i_stall,
  input  logic                 i_branch_valid,
  input  logic [PC_WIDTH-1:0]  i_branch_target,
  input  logic                 i_pc_ready,
  output logic [PC_WIDTH-1:0]  o_pc,
  output logic                 o_pc_valid,
  output logic [CNT_WIDTH-1:0] o_retired_count,
  output logic                 o_busy,
  output logic                 o_done
);
  typedef enum logic [2:0] {IDLE, RUN, STEP_WAIT, STEP_ISSUE, DONE} state_t;
  state_t r_state, w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_WIDTH-1:0] r_cnt, r_run_count, w_cnt_inc;
  logic r_limited;
  logic w_valid, w_issue, w_branch, w_start, w_limit_hit;
  assign w_valid = r_state == RUN || r_state == STEP_ISSUE;
  assign w_issue = w_valid && i_pc_ready && !i_stall;
  assign w_branch = i_branch_valid && (r_state == RUN || r_state == STEP_WAIT || r_state == STEP_ISSUE);
  assign w_start = r_state == IDLE && i_start;
  assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
  // Mode 11 is latched as free-run, so only 01 ever arms the limit.
  assign w_limit_hit = r_limited && w_issue && w_cnt_inc == r_run_count;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (i_start) w_next = i_mode == 2'b10 ? STEP_WAIT : (i_mode == 2'b01 && i_run_count == '0) ? DONE : RUN;
      RUN: if (i_halt || w_limit_hit) w_next = DONE;
      STEP_WAIT: w_next = i_halt ? DONE : i_step ? STEP_ISSUE : STEP_WAIT;
      STEP_ISSUE: w_next = i_halt ? DONE : w_issue ? STEP_WAIT : STEP_ISSUE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
      r_cnt <= '0;
      r_run_count <= '0;
      r_limited <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_pc <= i_start_pc;
        r_cnt <= '0;
        r_run_count <= i_run_count;
        r_limited <= i_mode == 2'b01;
      end else begin
        if (w_branch) r_pc <= i_branch_target;
        else if (w_issue) r_pc <= r_pc + PC_WIDTH'(PC_STEP);
        if (w_issue) r_cnt <= w_cnt_inc;
      end
    end
  end
  assign o_pc = r_pc;
  assign o_pc_valid = w_valid;
  assign o_retired_count = r_cnt;
  assign o_busy = r_state != IDLE;
  assign o_done = r_state == DONE;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: three differently parametrised sequencers share one directed stimulus stream and are
// checked each cycle against a phase-level reference model, plus literal expectations from hand analysis.
module tb_pc_sequencer;
  logic clk = 0, reset = 0, start = 0, step = 0, halt = 0, stall = 0, branch_valid = 0, pc_ready = 0;
  logic [1:0] mode = 0;
  logic [15:0] run_count = 0;
  logic [31:0] start_pc = 0, branch_target = 0;
  logic [31:0] pc_a, pc_b;
  logic [7:0] pc_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0] cnt_c;
  logic [2:0] valid, busy, done;
  logic [31:0] d_pc[3], d_cnt[3];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  pc_sequencer dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_run_count(run_count),
    .i_start_pc(start_pc), .i_step(step), .i_halt(halt), .i_stall(stall), .i_branch_valid(branch_valid),
    .i_branch_target(branch_target), .i_pc_ready(pc_ready), .o_pc(pc_a), .o_pc_valid(valid[0]),
    .o_retired_count(cnt_a), .o_busy(busy[0]), .o_done(done[0]));
  pc_sequencer #(.PC_STEP(4)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_run_count(run_count),
    .i_start_pc(start_pc), .i_step(step), .i_halt(halt), .i_stall(stall), .i_branch_valid(branch_valid),
    .i_branch_target(branch_target), .i_pc_ready(pc_ready), .o_pc(pc_b), .o_pc_valid(valid[1]),
    .o_retired_count(cnt_b), .o_busy(busy[1]), .o_done(done[1]));
  pc_sequencer #(.PC_WIDTH(8), .PC_STEP(1), .RESET_PC(8'h5A), .CNT_WIDTH(4)) dut_c (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_run_count(run_count[3:0]),
    .i_start_pc(start_pc[7:0]), .i_step(step), .i_halt(halt), .i_stall(stall), .i_branch_valid(branch_valid),
    .i_branch_target(branch_target[7:0]), .i_pc_ready(pc_ready), .o_pc(pc_c), .o_pc_valid(valid[2]),
    .o_retired_count(cnt_c), .o_busy(busy[2]), .o_done(done[2]));
  assign d_pc[0] = pc_a;
  assign d_pc[1] = pc_b;
  assign d_pc[2] = {24'b0, pc_c};
  assign d_cnt[0] = {16'b0, cnt_a};
  assign d_cnt[1] = {16'b0, cnt_b};
  assign d_cnt[2] = {28'b0, cnt_c};

  // Reference model: per-instance run phase, pc and issue count.
  localparam int P_IDLE = 0, P_RUN = 1, P_WAIT = 2, P_OFFER = 3, P_FIN = 4;
  int stepk[3] = '{1, 4, 1};
  int cmax[3] = '{65535, 65535, 15};
  logic [31:0] pmask[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] rpc[3] = '{32'h0, 32'h0, 32'h5A};
  int ph[3] = '{P_IDLE, P_IDLE, P_IDLE};
  logic [31:0] mpc[3] = '{32'h0, 32'h0, 32'h5A};
  int mcnt[3] = '{0, 0, 0};
  int mlim[3] = '{0, 0, 0};
  bit mlimd[3] = '{0, 0, 0};
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit off, iss, red;
      if (!reset) begin
        ph[k] = P_IDLE;
        mpc[k] = rpc[k];
        mcnt[k] = 0;
      end else begin
        off = ph[k] == P_RUN || ph[k] == P_OFFER;
        iss = off && pc_ready && !stall;
        red = branch_valid && (ph[k] == P_RUN || ph[k] == P_WAIT || ph[k] == P_OFFER);
        if (iss && mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
        if (red) mpc[k] = branch_target & pmask[k];
        else if (iss) mpc[k] = (mpc[k] + stepk[k]) & pmask[k];
        case (ph[k])
          P_IDLE: if (start) begin
            mpc[k] = start_pc & pmask[k];
            mcnt[k] = 0;
            mlimd[k] = mode == 2'b01;
            mlim[k] = int'(run_count) & cmax[k];
            ph[k] = mode == 2'b10 ? P_WAIT : (mode == 2'b01 && mlim[k] == 0) ? P_FIN : P_RUN;
          end
          P_RUN: if (halt || (mlimd[k] && iss && mcnt[k] == mlim[k])) ph[k] = P_FIN;
          P_WAIT: ph[k] = halt ? P_FIN : step ? P_OFFER : P_WAIT;
          P_OFFER: ph[k] = halt ? P_FIN : iss ? P_WAIT : P_OFFER;
          default: ph[k] = P_IDLE;
        endcase
      end
    end
  end

  task automatic chk(string nm, int k, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("pc", k, d_pc[k], mpc[k]);
      chk("pc_valid", k, {31'b0, valid[k]}, {31'b0, ph[k] == P_RUN || ph[k] == P_OFFER});
      chk("retired_count", k, d_cnt[k], mcnt[k]);
      chk("busy", k, {31'b0, busy[k]}, {31'b0, ph[k] != P_IDLE});
      chk("done", k, {31'b0, done[k]}, {31'b0, ph[k] == P_FIN});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done(int k);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done[k]) break;
    end
    chk("done_seen", k, {31'b0, done[k]}, 1);
  endtask
  task automatic idle_all();
    halt = 1;
    tick();
    halt = 0;
    tick();
    tick();
  endtask
  task automatic go(logic [1:0] m, logic [15:0] rc, logic [31:0] spc);
    mode = m;
    run_count = rc;
    start_pc = spc;
    start = 1;
    tick();
    start = 0;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_pc", 0, pc_a, 0);
    chk("rst_pc", 2, {24'b0, pc_c}, 32'h5A);
    chk("rst_busy", 0, {31'b0, busy[0]}, 0);
    chk("rst_cnt", 0, {16'b0, cnt_a}, 0);
    reset = 1;
    tick();
    // count-limited run with backpressure and an ignored start
    pc_ready = 1;
    go(2'b01, 16'd34, 32'h0);
    chk("first_valid", 0, {31'b0, valid[0]}, 1);
    chk("first_pc", 0, pc_a, 0);
    repeat (5) tick();
    chk("pc_at_5", 0, pc_a, 5);
    pc_ready = 0;
    repeat (3) tick();
    chk("ready_hold_pc", 0, pc_a, 5);
    chk("ready_hold_cnt", 0, {16'b0, cnt_a}, 5);
    pc_ready = 1;
    stall = 1;
    start = 1;
    mode = 2'b10;
    tick();
    start = 0;
    tick();
    stall = 0;
    chk("stall_hold_pc", 0, pc_a, 5);
    chk("stall_hold_cnt", 0, {16'b0, cnt_a}, 5);
    tick();
    chk("resume_pc", 0, pc_a, 6);
    wait_done(0);
    chk("limit_cnt", 0, {16'b0, cnt_a}, 34);
    chk("limit_pc", 0, pc_a, 34);
    tick();
    chk("busy_after_done", 0, {31'b0, busy[0]}, 0);
    // branch redirects
    idle_all();
    go(2'b00, 16'd0, 32'h0);
    repeat (7) tick();
    chk("pre_branch_pc", 0, pc_a, 7);
    branch_valid = 1;
    branch_target = 32'h40;
    tick();
    branch_valid = 0;
    chk("branch_pc", 0, pc_a, 32'h40);
    chk("branch_cnt", 0, {16'b0, cnt_a}, 8);
    pc_ready = 0;
    branch_valid = 1;
    branch_target = 32'h80;
    tick();
    branch_valid = 0;
    chk("stalled_branch_pc", 0, pc_a, 32'h80);
    chk("stalled_branch_cnt", 0, {16'b0, cnt_a}, 8);
    pc_ready = 1;
    repeat (2) tick();
    halt = 1;
    tick();
    halt = 0;
    chk("halt_done", 0, {31'b0, done[0]}, 1);
    chk("halt_cnt", 0, {16'b0, cnt_a}, 11);
    chk("halt_pc", 0, pc_a, 32'h83);
    // single-step on the PC_STEP=4 instance
    idle_all();
    go(2'b10, 16'd0, 32'h100);
    chk("step_idle_valid", 1, {31'b0, valid[1]}, 0);
    tick();
    chk("step_idle_pc", 1, pc_b, 32'h100);
    step = 1;
    tick();
    step = 0;
    chk("step_offer", 1, {31'b0, valid[1]}, 1);
    pc_ready = 0;
    step = 1;
    tick();
    step = 0;
    pc_ready = 1;
    tick();
    chk("step1_pc", 1, pc_b, 32'h104);
    chk("step1_cnt", 1, {16'b0, cnt_b}, 1);
    tick();
    chk("no_queued_step", 1, {31'b0, valid[1]}, 0);
    for (int i = 0; i < 2; i++) begin
      step = 1;
      tick();
      step = 0;
      tick();
    end
    halt = 1;
    step = 1;
    tick();
    halt = 0;
    step = 0;
    chk("step_done", 1, {31'b0, done[1]}, 1);
    chk("step_cnt", 1, {16'b0, cnt_b}, 3);
    chk("step_pc", 1, pc_b, 32'h10C);
    // wrap on the 8-bit instance
    idle_all();
    go(2'b01, 16'd4, 32'hFE);
    chk("wrap_pc0", 2, {24'b0, pc_c}, 32'hFE);
    tick();
    chk("wrap_pc1", 2, {24'b0, pc_c}, 32'hFF);
    tick();
    chk("wrap_pc2", 2, {24'b0, pc_c}, 32'h00);
    wait_done(2);
    chk("wrap_pc_end", 2, {24'b0, pc_c}, 32'h02);
    chk("wrap_cnt", 2, {28'b0, cnt_c}, 4);
    chk("nowrap_pc_end", 0, pc_a, 32'h102);
    // zero-length count-limited run
    idle_all();
    go(2'b01, 16'd0, 32'h33);
    chk("zero_done", 0, {31'b0, done[0]}, 1);
    chk("zero_valid", 0, {31'b0, valid[0]}, 0);
    chk("zero_pc", 0, pc_a, 32'h33);
    // counter saturation on the 4-bit counter instance
    idle_all();
    go(2'b00, 16'd0, 32'h0);
    repeat (20) tick();
    chk("sat_cnt", 2, {28'b0, cnt_c}, 15);
    chk("unsat_cnt", 0, {16'b0, cnt_a}, 20);
    halt = 1;
    tick();
    halt = 0;
    // reset mid-run
    idle_all();
    go(2'b11, 16'd0, 32'h10);
    repeat (3) tick();
    reset = 0;
    tick();
    reset = 1;
    chk("abort_busy", 0, {31'b0, busy[0]}, 0);
    chk("abort_pc", 0, pc_a, 0);
    chk("abort_pc", 2, {24'b0, pc_c}, 32'h5A);
    chk("abort_done", 0, {31'b0, done[0]}, 0);
    tick();
    chk("abort_no_done", 0, {31'b0, done[0]}, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer that drives the single-cycle processor's `pcounter` input.
- Replaces the fixed-increment bench stimulus loop with a reusable, synthesizable fetch controller.
- Supports free-run, count-limited and single-step modes, branch redirect, stall/backpressure and halt.
- Reports the number of issued instructions and a completion pulse; used both in the SCP top level and in processor benches.

Parameters:
- PC_WIDTH, 32, width of pc / start_pc / branch_target.
- PC_STEP, 1, increment per issued instruction (1 = word-indexed IMEM, 4 = byte-addressed).
- RESET_PC, 0, pc value after reset.
- CNT_WIDTH, 16, width of run_count / retired_count.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a run; accepted only in IDLE.
- mode  in  2  00 free-run, 01 count-limited, 10 single-step, 11 reserved (treated as 00); latched on start.
- run_count  in  CNT_WIDTH  instructions to issue in mode 01; latched on start.
- start_pc  in  PC_WIDTH  pc loaded on start.
- step  in  1  single-step advance request (mode 10).
- halt  in  1  stop request, any active state.
- stall  in  1  processor stall; blocks issue.
- branch_valid  in  1  redirect request.
- branch_target  in  PC_WIDTH  redirect address.
- pc_ready  in  1  processor accepts current pc.
- pc  out  PC_WIDTH  current program counter.
- pc_valid  out  1  pc is offered for issue.
- retired_count  out  CNT_WIDTH  instructions issued in the current/last run.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, pc=RESET_PC, pc_valid=0, retired_count=0, busy=0, done=0.
  - Overrides every other input.
  - Reset mid-run aborts with no done pulse.
- FSM states: IDLE, RUN, STEP_WAIT, STEP_ISSUE, DONE.
- IDLE:
  - On start: pc<=start_pc, retired_count<=0, latch mode and run_count.
  - Next state: mode 10 -> STEP_WAIT; mode 01 with run_count==0 -> DONE (zero issues); otherwise -> RUN.
  - start in any other state is ignored.
- Issue event: pc_valid && pc_ready && !stall in the same cycle.
  - On issue: retired_count<=retired_count+1, saturating at all-ones.
- Next pc:
  - Issue without branch: pc<=pc+PC_STEP, truncated mod 2^PC_WIDTH (wrap, no flag).
  - branch_valid in RUN/STEP_WAIT/STEP_ISSUE: pc<=branch_target next cycle. This takes priority over increment, with or without a coincident issue.
  - A coincident issue is still counted.
  - No issue and no branch: pc holds stable.
- RUN:
  - pc_valid=1.
  - Mode 01: the issue that makes retired_count==run_count -> DONE.
  - halt -> DONE; a coincident issue is still counted.
- STEP_WAIT:
  - pc_valid=0.
  - step -> STEP_ISSUE.
  - halt -> DONE; halt has priority over step.
- STEP_ISSUE:
  - pc_valid=1.
  - issue -> STEP_WAIT.
  - halt -> DONE.
  - step pulses received here are ignored (not queued).
- DONE:
  - pc_valid=0, done=1 for exactly one cycle, then -> IDLE.
  - pc and retired_count keep their final values until the next start or reset.
- busy:
  - Low only in IDLE.
  - start is sampled in IDLE only, so start on the DONE cycle is ignored.
- Latency: first pc_valid appears the cycle after start is accepted; in RUN with pc_ready=1 and stall=0, one issue per cycle.

Test Plan:
- Count-limited run: reset, start mode=01 run_count=34 start_pc=0, pc_ready=1 -> pc 0..33 on consecutive cycles; retired_count=34; done high one cycle after the 34th issue; busy low next cycle.
- Backpressure: during the run, drive pc_ready=0 for 3 cycles at pc=5, then stall=1 for 2 cycles -> pc stays 5 and retired_count stays frozen throughout; resumes at 6 after release.
- Branch: branch_valid with branch_target=0x40 coincident with issue at pc=7 -> next pc=0x40, count includes pc=7; a branch while pc_ready=0 also redirects.
- Single-step with PC_STEP=4: mode=10 start_pc=0x100 -> pc_valid low until step; each step gives exactly one issue (0x100, 0x104, 0x108); halt in STEP_WAIT -> done pulse, retired_count=3.
- Wrap: PC_WIDTH=8, start_pc=0xFE, mode=01, run_count=4 -> pc FE, FF, 00, 01; done asserted.
- Edge cases:
  - run_count=0 -> done one cycle after start with no pc_valid.
  - halt asserted with a coincident issue -> that issue is counted.
  - reset low mid-run -> pc=RESET_PC, busy=0, no done pulse.
  - start while busy -> ignored.
